// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: state encoding and instruction-memory geometry shared with the PC and imem
package imem_loader_pkg;
  localparam int IMEM_ADDR_W = 9;
  localparam int IMEM_DATA_W = 16;
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    HI   = 3'd1,
    LO   = 3'd2,
    CHK  = 3'd3,
    DONE = 3'd4,
    ERR  = 3'd5
  } state_t;
endpackage

// File: rtl/imem_loader_if.sv
// imem_loader_if: control, byte stream and imem write port of the loader
// i_start/i_load_len: load request; i_byte/i_byte_valid/o_byte_ready: byte stream handshake
// o_wr_en/o_wr_addr/o_wr_data: imem write port; o_cpu_rst/o_busy/o_done/o_err/o_words_loaded: status
interface imem_loader_if import imem_loader_pkg::*; #(
  parameter int ADDR_W = IMEM_ADDR_W,
  parameter int DATA_W = IMEM_DATA_W,
  parameter int LEN_W  = ADDR_W + 1
) ();
  logic              i_start;
  logic [LEN_W-1:0]  i_load_len;
  logic [7:0]        i_byte;
  logic              i_byte_valid;
  logic              o_byte_ready;
  logic              o_wr_en;
  logic [ADDR_W-1:0] o_wr_addr;
  logic [DATA_W-1:0] o_wr_data;
  logic              o_cpu_rst;
  logic              o_busy;
  logic              o_done;
  logic              o_err;
  logic [LEN_W-1:0]  o_words_loaded;
  modport slave (
    input  i_start, i_load_len, i_byte, i_byte_valid,
    output o_byte_ready, o_wr_en, o_wr_addr, o_wr_data, o_cpu_rst, o_busy, o_done, o_err, o_words_loaded
  );
  modport master (
    output i_start, i_load_len, i_byte, i_byte_valid,
    input  o_byte_ready, o_wr_en, o_wr_addr, o_wr_data, o_cpu_rst, o_busy, o_done, o_err, o_words_loaded
  );
endinterface

// File: rtl/imem_loader.sv
// imem_loader: fills instruction memory from a byte stream, verifies an XOR trailer, gates core reset
// clk, rst_n: clock and asynchronous active-low reset
// bus (slave): load request, byte stream handshake, imem write port and load status
module imem_loader import imem_loader_pkg::*; #(
  parameter int ADDR_W    = IMEM_ADDR_W,
  parameter int DATA_W    = IMEM_DATA_W,
  parameter int MAX_WORDS = 2 ** ADDR_W
) (
  input logic          clk,
  input logic          rst_n,
  imem_loader_if.slave bus
);
  localparam int LEN_W = ADDR_W + 1;
  state_t            r_state, w_next;
  logic [LEN_W-1:0]  r_len, r_cnt;
  logic [7:0]        r_hi, r_csum;
  logic              r_wr_en;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [DATA_W-1:0] r_wr_data;
  logic              w_ready, w_xfer, w_len_ok, w_accept;
  assign w_ready  = r_state inside {HI, LO, CHK};
  assign w_xfer   = w_ready && bus.i_byte_valid;
  assign w_len_ok = bus.i_load_len != '0 && bus.i_load_len <= LEN_W'(MAX_WORDS);
  assign w_accept = r_state inside {IDLE, DONE, ERR} && bus.i_start && w_len_ok;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      HI:      w_next = w_xfer ? LO : HI;
      LO:      w_next = !w_xfer ? LO : (r_cnt == r_len - LEN_W'(1)) ? CHK : HI;
      CHK:     w_next = !w_xfer ? CHK : (bus.i_byte == r_csum) ? DONE : ERR;
      default: w_next = !bus.i_start ? r_state : w_len_ok ? HI : ERR;
    endcase
  end
  // the counter advances on the low-byte edge, so words_loaded already counts the word while wr_en is high
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_len     <= '0;
      r_cnt     <= '0;
      r_hi      <= '0;
      r_csum    <= '0;
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
    end else begin
      r_wr_en <= 1'b0;
      if (w_accept) begin
        r_len  <= bus.i_load_len;
        r_cnt  <= '0;
        r_csum <= '0;
      end
      if (w_xfer && r_state != CHK) r_csum <= r_csum ^ bus.i_byte;
      if (w_xfer && r_state == HI) r_hi <= bus.i_byte;
      if (w_xfer && r_state == LO) begin
        r_wr_en   <= 1'b1;
        r_wr_addr <= r_cnt[ADDR_W-1:0];
        r_wr_data <= {r_hi, bus.i_byte};
        r_cnt     <= r_cnt + LEN_W'(1);
      end
    end
  assign bus.o_byte_ready   = w_ready;
  assign bus.o_busy         = w_ready;
  assign bus.o_done         = r_state == DONE;
  assign bus.o_cpu_rst      = r_state == DONE;
  assign bus.o_err          = r_state == ERR;
  assign bus.o_wr_en        = r_wr_en;
  assign bus.o_wr_addr      = r_wr_addr;
  assign bus.o_wr_data      = r_wr_data;
  assign bus.o_words_loaded = r_cnt;
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed loads checked against a byte-count model of the loader every cycle
module tb_imem_loader;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  imem_loader_if bus ();
  imem_loader dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  int n_checks = 0;
  int n_err = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  logic        m_busy = 0, m_done = 0, m_err = 0, m_wr = 0;
  int          m_len = 0, m_wcount = 0;
  logic [8:0]  m_addr = '0;
  logic [15:0] m_data = '0;
  logic [7:0]  m_bytes[$];
  logic [8:0]  log_addr[$];
  logic [15:0] log_data[$];
  always @(negedge clk) begin : model
    int n;
    logic [7:0] x;
    if (!rst_n) begin
      m_busy = 0; m_done = 0; m_err = 0; m_wr = 0;
      m_wcount = 0; m_addr = '0; m_data = '0;
      m_bytes.delete();
    end
    chk("byte_ready", 32'(bus.o_byte_ready), 32'(m_busy));
    chk("busy", 32'(bus.o_busy), 32'(m_busy));
    chk("done", 32'(bus.o_done), 32'(m_done));
    chk("cpu_rst", 32'(bus.o_cpu_rst), 32'(m_done));
    chk("err", 32'(bus.o_err), 32'(m_err));
    chk("wr_en", 32'(bus.o_wr_en), 32'(m_wr));
    chk("wr_addr", 32'(bus.o_wr_addr), 32'(m_addr));
    chk("wr_data", 32'(bus.o_wr_data), 32'(m_data));
    chk("words_loaded", 32'(bus.o_words_loaded), 32'(m_wcount));
    if (bus.o_wr_en) begin
      log_addr.push_back(bus.o_wr_addr);
      log_data.push_back(bus.o_wr_data);
    end
    if (rst_n) begin
      m_wr = 0;
      if (bus.i_start && !m_busy) begin
        if (bus.i_load_len == 0 || bus.i_load_len > 512) begin
          m_err = 1; m_done = 0;
        end else begin
          m_busy = 1; m_done = 0; m_err = 0;
          m_len = int'(bus.i_load_len); m_wcount = 0;
          m_bytes.delete();
        end
      end else if (m_busy && bus.i_byte_valid) begin
        m_bytes.push_back(bus.i_byte);
        n = m_bytes.size();
        if (n % 2 == 0 && n <= 2 * m_len) begin
          m_wr = 1;
          m_addr = 9'(n / 2 - 1);
          m_data = {m_bytes[n-2], m_bytes[n-1]};
          m_wcount = n / 2;
        end else if (n == 2 * m_len + 1) begin
          x = '0;
          foreach (m_bytes[i]) x ^= m_bytes[i];
          m_busy = 0;
          m_done = (x == 8'h00);
          m_err = (x != 8'h00);
        end
      end
    end
  end
  task automatic do_start(input int len);
    @(posedge clk); #1;
    bus.i_load_len = 10'(len);
    bus.i_start = 1'b1;
    @(posedge clk); #1;
    bus.i_start = 1'b0;
  endtask
  task automatic send(input logic [7:0] b, input int gap);
    logic rdy;
    bus.i_byte_valid = 1'b0;
    repeat (gap) begin
      @(posedge clk); #1;
    end
    bus.i_byte = b;
    bus.i_byte_valid = 1'b1;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      rdy = bus.o_byte_ready;
      @(posedge clk); #1;
      if (rdy) begin
        bus.i_byte_valid = 1'b0;
        return;
      end
    end
    n_checks++;
    n_err++;
    $display("FAIL send_timeout: byte %0h not accepted within 100 cycles", b);
    bus.i_byte_valid = 1'b0;
  endtask
  task automatic wait_end();
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (bus.o_done || bus.o_err) return;
    end
    n_checks++;
    n_err++;
    $display("FAIL wait_end: no done/err within 50 cycles");
  endtask
  task automatic send_stream(input logic [7:0] trailer, input int g0, input int g1, input int g2, input int g3, input int g4);
    send(8'h12, g0);
    send(8'h34, g1);
    send(8'hAB, g2);
    send(8'hCD, g3);
    send(trailer, g4);
  endtask
  task automatic chk_two_writes(input string tag);
    chk({tag, "_nwr"}, 32'(log_addr.size()), 32'd2);
    if (log_addr.size() == 2) begin
      chk({tag, "_a0"}, 32'(log_addr[0]), 32'd0);
      chk({tag, "_d0"}, 32'(log_data[0]), 32'h1234);
      chk({tag, "_a1"}, 32'(log_addr[1]), 32'd1);
      chk({tag, "_d1"}, 32'(log_data[1]), 32'hABCD);
    end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    bus.i_start = 1'b0;
    bus.i_load_len = '0;
    bus.i_byte = '0;
    bus.i_byte_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cpu_rst", 32'(bus.o_cpu_rst), 32'd0);
    chk("rst_ready", 32'(bus.o_byte_ready), 32'd0);
    chk("rst_words", 32'(bus.o_words_loaded), 32'd0);
    rst_n = 1'b1;
    log_addr.delete(); log_data.delete();
    do_start(2);
    send_stream(8'h40, 0, 0, 0, 0, 0);
    wait_end();
    chk("norm_done", 32'(bus.o_done), 32'd1);
    chk("norm_cpu_rst", 32'(bus.o_cpu_rst), 32'd1);
    chk("norm_words", 32'(bus.o_words_loaded), 32'd2);
    chk_two_writes("norm");
    log_addr.delete(); log_data.delete();
    do_start(2);
    send_stream(8'h41, 0, 0, 0, 0, 0);
    wait_end();
    chk("bad_err", 32'(bus.o_err), 32'd1);
    chk("bad_done", 32'(bus.o_done), 32'd0);
    chk("bad_cpu_rst", 32'(bus.o_cpu_rst), 32'd0);
    chk_two_writes("bad");
    log_addr.delete(); log_data.delete();
    do_start(0);
    @(negedge clk);
    chk("len0_err", 32'(bus.o_err), 32'd1);
    do_start(513);
    @(negedge clk);
    chk("len513_err", 32'(bus.o_err), 32'd1);
    chk("illegal_nwr", 32'(log_addr.size()), 32'd0);
    do_start(2);
    send_stream(8'h40, 2, 0, 3, 1, 2);
    wait_end();
    chk("bp_done", 32'(bus.o_done), 32'd1);
    chk_two_writes("bp");
    log_addr.delete(); log_data.delete();
    do_start(2);
    send(8'h12, 0);
    send(8'h34, 0);
    send(8'hAB, 0);
    rst_n = 1'b0;
    #1;
    chk("mrst_busy", 32'(bus.o_busy), 32'd0);
    chk("mrst_wr_addr", 32'(bus.o_wr_addr), 32'd0);
    chk("mrst_wr_data", 32'(bus.o_wr_data), 32'd0);
    chk("mrst_words", 32'(bus.o_words_loaded), 32'd0);
    chk("mrst_cpu_rst", 32'(bus.o_cpu_rst), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("mrst_nwr", 32'(log_addr.size()), 32'd1);
    log_addr.delete(); log_data.delete();
    do_start(2);
    send_stream(8'h40, 0, 0, 0, 0, 0);
    wait_end();
    chk("reload_done", 32'(bus.o_done), 32'd1);
    chk_two_writes("reload");
    log_addr.delete(); log_data.delete();
    do_start(512);
    do_start(3);
    for (int k = 0; k < 1024; k++) send(8'(k), 0);
    send(8'h00, 0);
    wait_end();
    chk("full_done", 32'(bus.o_done), 32'd1);
    chk("full_words", 32'(bus.o_words_loaded), 32'd512);
    chk("full_nwr", 32'(log_addr.size()), 32'd512);
    if (log_addr.size() == 512) begin
      chk("full_d0", 32'(log_data[0]), 32'h0001);
      chk("full_last_a", 32'(log_addr[511]), 32'd511);
      chk("full_last_d", 32'(log_data[511]), 32'hFEFF);
    end
    log_addr.delete(); log_data.delete();
    do_start(2);
    chk("restart_cpu_rst", 32'(bus.o_cpu_rst), 32'd0);
    chk("restart_busy", 32'(bus.o_busy), 32'd1);
    send_stream(8'h40, 0, 1, 0, 0, 0);
    wait_end();
    chk("restart_done", 32'(bus.o_done), 32'd1);
    chk_two_writes("restart");
    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
